// File: rtl/trig_pulse_gen.sv
// trig_pulse_gen: multi-channel programmable trigger generator with phase delay and continuous/one-shot/burst modes
module trig_pulse_gen #(
    parameter int N_CH    = 2,
    parameter int CNT_W   = 32,
    parameter int BURST_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          start_i,
    input  logic [N_CH-1:0]          stop_i,
    input  logic [N_CH*CNT_W-1:0]    div_i,
    input  logic [N_CH*CNT_W-1:0]    phase_i,
    input  logic [N_CH*2-1:0]        mode_i,
    input  logic [N_CH*BURST_W-1:0]  burst_i,
    output logic [N_CH-1:0]          trigger_o,
    output logic [N_CH-1:0]          busy_o,
    output logic [N_CH-1:0]          done_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RUN} state_t;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t             st;
        logic [CNT_W-1:0]   cnt, div_s, phase_s, nxt, div_k, phase_k;
        logic [BURST_W-1:0] npulse, lim, burst_k;
        logic [1:0]         mode_k;
        logic               fin, trig, busy, done;

        assign div_k   = div_i[k*CNT_W +: CNT_W];
        assign phase_k = phase_i[k*CNT_W +: CNT_W];
        assign burst_k = burst_i[k*BURST_W +: BURST_W];
        assign mode_k  = mode_i[k*2 +: 2];
        // cnt is the position of the current cycle within the period; a pulse lands on position 0
        assign nxt     = (cnt == div_s - CNT_W'(1)) ? '0 : cnt + CNT_W'(1);

        always_ff @(posedge clk) begin
            if (rst) begin
                st      <= IDLE;
                cnt     <= '0;
                div_s   <= '0;
                phase_s <= '0;
                npulse  <= '0;
                lim     <= '0;
                fin     <= 1'b0;
                trig    <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                trig <= 1'b0;
                done <= 1'b0;
                case (st)
                    IDLE: if (start_i[k] && !stop_i[k]) begin
                        div_s   <= (div_k == '0) ? CNT_W'(1) : div_k;
                        phase_s <= phase_k;
                        lim     <= (mode_k == 2'b01 || burst_k == '0) ? BURST_W'(1) : burst_k;
                        fin     <= (mode_k == 2'b01) || (mode_k == 2'b10);
                        busy    <= 1'b1;
                        st      <= (phase_k == '0) ? RUN : WAIT;
                        trig    <= (phase_k == '0);
                        cnt     <= (phase_k == '0) ? '0 : CNT_W'(1);
                        npulse  <= (phase_k == '0) ? BURST_W'(1) : '0;
                    end
                    WAIT: if (stop_i[k]) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else if (cnt == phase_s) begin
                        st     <= RUN;
                        trig   <= 1'b1;
                        cnt    <= '0;
                        npulse <= BURST_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    RUN: if (stop_i[k] || (fin && npulse == lim)) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        cnt    <= nxt;
                        trig   <= (nxt == '0);
                        npulse <= npulse + BURST_W'(fin && nxt == '0);
                    end
                    default: st <= IDLE;
                endcase
            end
        end

        assign trigger_o[k] = trig;
        assign busy_o[k]    = busy;
        assign done_o[k]    = done;
    end
endmodule

// File: doc/trig_pulse_gen.md
Name: trig_pulse_gen

Overview:
Multi-channel programmable trigger generator. It is the parametrised successor to the single fixed-divider ILA trigger. Each channel independently emits single-cycle trigger pulses at a programmable period, after a programmable phase delay. Each channel runs in one of three modes: continuous, one-shot or N-pulse burst, under start/stop control. Config is driven from VIO or a register bank, and trigger outputs feed ILA trigger inputs or downstream capture logic.

Parameters:
N_CH, 2, number of independent channels (1..8)
CNT_W, 32, width of period and phase counters
BURST_W, 16, width of burst-length field

Ports:
clk  in  1  single clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
start_i  in  N_CH  per-channel start request, sampled each cycle
stop_i  in  N_CH  per-channel abort request, sampled each cycle
div_i  in  N_CH*CNT_W  period in cycles; channel k at bits [k*CNT_W +: CNT_W]
phase_i  in  N_CH*CNT_W  delay from start acceptance to first pulse
mode_i  in  N_CH*2  00 continuous, 01 one-shot, 10 burst, 11 reserved (treated as continuous)
burst_i  in  N_CH*BURST_W  pulse count for burst mode
trigger_o  out  N_CH  registered single-cycle trigger pulse
busy_o  out  N_CH  channel is in WAIT or RUN
done_o  out  N_CH  single-cycle pulse on completion or abort

Behaviour:
- Reset: all channels go to IDLE; trigger_o, busy_o and done_o are 0; counters are 0. If rst is asserted mid-run, the next cycle shows all outputs 0 and no done_o.
- All outputs are registered. There is no combinational path from any input to any output.
- Per-channel FSM: IDLE, WAIT, RUN. Channels are fully independent.
- IDLE:
  - If start_i[k]=1 and stop_i[k]=0 in cycle t, latch div/phase/mode/burst into shadow registers and go to WAIT.
  - busy_o=1 from cycle t+1.
- Shadow config is frozen while busy. Input changes take effect only at the next accepted start.
- Width rules for latched values:
  - div=0 is latched as 1 (pulse every cycle). No underflow wrap, unlike the old div-1 compare.
  - burst=0 is latched as 1.
  - Phase and period counters are CNT_W wide, and the pulse counter is BURST_W wide. Counters never wrap, because the compare is against the latched terminal value.
- Timing: the first trigger_o pulse is in cycle t+1+phase. Subsequent pulses occur every div cycles, i.e. t+1+phase+n*div.
  - WAIT counts phase cycles, then enters RUN. With phase=0, WAIT lasts 0 effective cycles and the first pulse occurs at t+1.
- RUN uses a period counter running 0..div-1. A pulse is issued when the counter reaches 0.
- Termination by mode:
  - Continuous: runs until stop.
  - One-shot: after the single pulse, done_o=1 in the next cycle, busy_o=0 in that same cycle, and the channel returns to IDLE.
  - Burst: after the burst-th pulse, done_o follows 1 cycle later and the channel returns to IDLE. There are no further pulses.
- stop_i[k]=1 in WAIT or RUN in cycle s:
  - Cycle s+1 has trigger_o=0, busy_o=0, done_o=1, and the channel is in IDLE.
  - A pulse scheduled in cycle s+1 is suppressed.
- stop_i in IDLE is ignored, with no done_o.
- start_i while busy is ignored, with no restart.
- start_i and stop_i in the same cycle: stop wins in every state.
- A new start in the same cycle that done_o is high is accepted, because the channel is already in IDLE. The first new pulse is then at +1+phase.
- Back-to-back minimum: with div=1 in continuous mode, trigger_o stays high every cycle.

Test Plan:
- Reset then start ch0 at cycle 10, div=5, phase=0, continuous -> trigger_o[0] at cycles 11,16,21,26...; busy_o[0] high from 11; stop at 30 -> busy_o 0 and done_o pulse at 31; no pulse at 31.
- ch1 one-shot, phase=3, start at 20 -> single pulse at 24, done_o at 25, busy_o low at 25; ch0 running concurrently is unaffected.
- Burst, div=4, phase=2, burst=3, start at 0 -> pulses at 3,7,11; done_o at 12; no pulse at 15.
- div=0 and burst=0 with burst mode -> exactly one pulse at start+1+phase, then done_o; div=1 continuous -> trigger_o constantly high until stop.
- Change div_i from 5 to 2 while running -> period stays 5; start while busy ignored; start+stop in the same cycle in IDLE -> stays IDLE with no done_o.
- Assert rst at a cycle where a pulse is due -> no pulse, all outputs 0 next cycle; restart works normally afterwards.
